// File: rtl/dmem_split_ctrl.sv
// RV32I data memory behind a valid/ready request port with a registered response.
// Word-crossing accesses are either split into two beats or rejected.
module dmem_split_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter bit          MISALIGN_SPLIT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int unsigned WORD_AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned BYTES    = 4 * DEPTH_WORDS;
  localparam int unsigned WIDX_W   = ADDR_WIDTH - 2;
  localparam int unsigned LAST_W   = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t state, next_state;

  logic [31:0] mem [DEPTH_WORDS];

  logic [WIDX_W-1:0] word0;
  logic [1:0]        off;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [31:0]       wdata_q;
  logic [31:0]       lo_word;

  logic              accept;
  logic [2:0]        req_size;
  logic [LAST_W-1:0] last_byte;
  logic              req_err;

  logic [3:0]        mask4;
  logic [7:0]        wide_be;
  logic [63:0]       wide_wd;
  logic              crossing;

  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wd;
  logic [WORD_AW-1:0] mem_idx;
  logic [31:0]       mem_rd;
  logic [63:0]       wide_rd;
  logic [31:0]       sh;
  logic [31:0]       load_val;

  // Accept-time legality checks on the raw request
  always_comb begin
    accept = req_valid && req_ready;
    case (req_funct3[1:0])
      2'd0:    req_size = 3'd1;
      2'd1:    req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
    last_byte = {1'b0, req_addr} + LAST_W'(req_size) - LAST_W'(1);
    req_err   = !(req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
              || (req_we && req_funct3[2])
              || (last_byte >= LAST_W'(BYTES))
              || (!MISALIGN_SPLIT && ((3'(req_addr[1:0]) + req_size) > 3'd4));
  end

  // Lane mask and data spread over a two-word window starting at word0
  always_comb begin
    case (funct3_q[1:0])
      2'd0:    mask4 = 4'b0001;
      2'd1:    mask4 = 4'b0011;
      default: mask4 = 4'b1111;
    endcase
    wide_be  = {4'b0000, mask4} << off;
    wide_wd  = {32'b0, wdata_q} << {off, 3'b000};
    crossing = |wide_be[7:4];
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin : next_state_logic
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = req_err ? RESP : BEAT0;
      BEAT0:   next_state = crossing ? BEAT1 : RESP;
      BEAT1:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin : output_logic
    mem_we  = 1'b0;
    mem_be  = 4'b0000;
    mem_wd  = 32'b0;
    mem_idx = WORD_AW'(word0);
    wide_rd = 64'b0;
    case (state)
      BEAT0: begin
        mem_we = we_q;
        mem_be = wide_be[3:0];
        mem_wd = wide_wd[31:0];
      end
      BEAT1: begin
        mem_we  = we_q;
        mem_be  = wide_be[7:4];
        mem_wd  = wide_wd[63:32];
        mem_idx = WORD_AW'(word0 + WIDX_W'(1));
      end
      default: ;
    endcase
    mem_rd  = mem[mem_idx];
    wide_rd = (state == BEAT1) ? {mem_rd, lo_word} : {32'b0, mem_rd};
    sh      = 32'(wide_rd >> {off, 3'b000});
    case (funct3_q)
      3'd0:    load_val = {{24{sh[7]}}, sh[7:0]};
      3'd1:    load_val = {{16{sh[15]}}, sh[15:0]};
      3'd4:    load_val = {24'b0, sh[7:0]};
      3'd5:    load_val = {16'b0, sh[15:0]};
      default: load_val = sh;
    endcase
  end

  // Request latch, low-word capture and registered response
  always_ff @(posedge clk or negedge rst_n) begin : datapath
    if (!rst_n) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'b0;
      resp_err   <= 1'b0;
      word0      <= '0;
      off        <= 2'b0;
      we_q       <= 1'b0;
      funct3_q   <= 3'b0;
      wdata_q    <= 32'b0;
      lo_word    <= 32'b0;
    end else begin
      req_ready  <= (next_state == IDLE);
      resp_valid <= (next_state == RESP);
      if (accept) begin
        word0    <= req_addr[ADDR_WIDTH-1:2];
        off      <= req_addr[1:0];
        we_q     <= req_we;
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata;
      end
      if (state == BEAT0) lo_word <= mem_rd;
      if (next_state == RESP) begin
        resp_err   <= (state == IDLE);
        resp_rdata <= ((state == IDLE) || we_q) ? 32'b0 : load_val;
      end else begin
        resp_err   <= 1'b0;
        resp_rdata <= 32'b0;
      end
    end
  end

  // Storage is not reset; an aborted split store keeps whatever BEAT0 committed
  always_ff @(posedge clk) begin : mem_write
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_split_ctrl.sv
// Directed bench for dmem_split_ctrl: three instances cover split mode, trap mode
// with a 16-word memory, and split mode with a 16-word memory.
module tb_dmem_split_ctrl;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  vld = 3'b000;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic        rdy [3];
  logic        rv  [3];
  logic        er  [3];
  logic [31:0] rd  [3];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dmem_split_ctrl #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .MISALIGN_SPLIT(1'b1)) u_split (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_err(er[0]));

  dmem_split_ctrl #(.ADDR_WIDTH(32), .DEPTH_WORDS(16), .MISALIGN_SPLIT(1'b0)) u_trap (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_err(er[1]));

  dmem_split_ctrl #(.ADDR_WIDTH(32), .DEPTH_WORDS(16), .MISALIGN_SPLIT(1'b1)) u_small (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[2]), .req_ready(rdy[2]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(rv[2]), .resp_rdata(rd[2]), .resp_err(er[2]));

  // One request on instance d; reports response, latency, busy cycles and pulse count
  task automatic run_req(input int d, input vec_t v, output logic [31:0] rdata,
                         output logic rerr, output int lat, output int busy, output int pulses);
    int n;
    rdata = 32'b0; rerr = 1'b0; lat = 0; busy = 0; pulses = 0;
    @(negedge clk);
    req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_funct3 = v.f3;
    vld = 3'b000; vld[d] = 1'b1;
    @(posedge clk); #1;
    vld = 3'b000;
    n = 1;
    while (n <= 12) begin
      if (rv[d]) begin
        if (pulses == 0) begin lat = n; rdata = rd[d]; rerr = er[d]; end
        pulses++;
      end
      if (rdy[d]) break;
      busy++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      total++; if (rdy[d] !== 1'b1) $display("FAIL reset[%0d] req_ready got %b exp 1", d, rdy[d]); else passed++;
      total++; if (rv[d] !== 1'b0) $display("FAIL reset[%0d] resp_valid got %b exp 0", d, rv[d]); else passed++;
      total++; if (rd[d] !== 32'h0) $display("FAIL reset[%0d] resp_rdata got %h exp 0", d, rd[d]); else passed++;
      total++; if (er[d] !== 1'b0) $display("FAIL reset[%0d] resp_err got %b exp 0", d, er[d]); else passed++;
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_access();
    vec_t v [2];
    logic [31:0] r; logic e; int lat, busy, pulses;
    v = '{'{1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0, 1'b0, 4'd2},
          '{1'b0, 32'h10, 32'h0,        3'd2, 32'hDEADBEEF, 1'b0, 4'd2}};
    for (int i = 0; i < 2; i++) begin
      run_req(0, v[i], r, e, lat, busy, pulses);
      total++; if (r !== v[i].rdata) $display("FAIL word[%0d] rdata got %h exp %h", i, r, v[i].rdata); else passed++;
      total++; if (e !== v[i].err) $display("FAIL word[%0d] err got %b exp %b", i, e, v[i].err); else passed++;
      total++; if (lat != int'(v[i].lat)) $display("FAIL word[%0d] latency got %0d exp %0d", i, lat, v[i].lat); else passed++;
      total++; if (pulses != 1) $display("FAIL word[%0d] resp pulses got %0d exp 1", i, pulses); else passed++;
    end
  endtask

  task automatic test_subword();
    vec_t v [9];
    logic [31:0] r; logic e; int lat, busy, pulses;
    v = '{'{1'b0, 32'h13, 32'h0,        3'd0, 32'hFFFFFFDE, 1'b0, 4'd2},
          '{1'b0, 32'h13, 32'h0,        3'd4, 32'h000000DE, 1'b0, 4'd2},
          '{1'b0, 32'h12, 32'h0,        3'd1, 32'hFFFFDEAD, 1'b0, 4'd2},
          '{1'b0, 32'h10, 32'h0,        3'd5, 32'h0000BEEF, 1'b0, 4'd2},
          '{1'b1, 32'h11, 32'hFFFFFF77, 3'd0, 32'h0,        1'b0, 4'd2},
          '{1'b0, 32'h10, 32'h0,        3'd2, 32'hDEAD77EF, 1'b0, 4'd2},
          '{1'b1, 32'h12, 32'hABCD1357, 3'd1, 32'h0,        1'b0, 4'd2},
          '{1'b0, 32'h10, 32'h0,        3'd2, 32'h135777EF, 1'b0, 4'd2},
          '{1'b0, 32'h11, 32'h0,        3'd1, 32'h00005777, 1'b0, 4'd2}};
    for (int i = 0; i < 9; i++) begin
      run_req(0, v[i], r, e, lat, busy, pulses);
      total++; if (r !== v[i].rdata) $display("FAIL subword[%0d] rdata got %h exp %h", i, r, v[i].rdata); else passed++;
      total++; if (e !== v[i].err) $display("FAIL subword[%0d] err got %b exp %b", i, e, v[i].err); else passed++;
      total++; if (lat != int'(v[i].lat)) $display("FAIL subword[%0d] latency got %0d exp %0d", i, lat, v[i].lat); else passed++;
    end
  endtask

  task automatic test_split();
    vec_t v [7];
    logic [31:0] r; logic e; int lat, busy, pulses;
    v = '{'{1'b1, 32'h23, 32'h11223344, 3'd2, 32'h0,        1'b0, 4'd3},
          '{1'b0, 32'h23, 32'h0,        3'd4, 32'h00000044, 1'b0, 4'd2},
          '{1'b0, 32'h24, 32'h0,        3'd4, 32'h00000033, 1'b0, 4'd2},
          '{1'b0, 32'h25, 32'h0,        3'd4, 32'h00000022, 1'b0, 4'd2},
          '{1'b0, 32'h26, 32'h0,        3'd4, 32'h00000011, 1'b0, 4'd2},
          '{1'b0, 32'h23, 32'h0,        3'd2, 32'h11223344, 1'b0, 4'd3},
          '{1'b0, 32'h23, 32'h0,        3'd5, 32'h00003344, 1'b0, 4'd3}};
    for (int i = 0; i < 7; i++) begin
      run_req(0, v[i], r, e, lat, busy, pulses);
      total++; if (r !== v[i].rdata) $display("FAIL split[%0d] rdata got %h exp %h", i, r, v[i].rdata); else passed++;
      total++; if (e !== v[i].err) $display("FAIL split[%0d] err got %b exp %b", i, e, v[i].err); else passed++;
      total++; if (lat != int'(v[i].lat)) $display("FAIL split[%0d] latency got %0d exp %0d", i, lat, v[i].lat); else passed++;
      total++; if (busy != int'(v[i].lat)) $display("FAIL split[%0d] ready-low cycles got %0d exp %0d", i, busy, v[i].lat); else passed++;
      total++; if (pulses != 1) $display("FAIL split[%0d] resp pulses got %0d exp 1", i, pulses); else passed++;
    end
  endtask

  task automatic test_trap();
    vec_t v [6];
    logic [31:0] r; logic e; int lat, busy, pulses;
    v = '{'{1'b1, 32'h04, 32'hCAFEF00D, 3'd2, 32'h0,        1'b0, 4'd2},
          '{1'b0, 32'h07, 32'h0,        3'd1, 32'h0,        1'b1, 4'd1},
          '{1'b1, 32'h07, 32'h00001234, 3'd1, 32'h0,        1'b1, 4'd1},
          '{1'b1, 32'h06, 32'h99999999, 3'd2, 32'h0,        1'b1, 4'd1},
          '{1'b0, 32'h04, 32'h0,        3'd2, 32'hCAFEF00D, 1'b0, 4'd2},
          '{1'b0, 32'h05, 32'h0,        3'd1, 32'hFFFFFEF0, 1'b0, 4'd2}};
    for (int i = 0; i < 6; i++) begin
      run_req(1, v[i], r, e, lat, busy, pulses);
      total++; if (r !== v[i].rdata) $display("FAIL trap[%0d] rdata got %h exp %h", i, r, v[i].rdata); else passed++;
      total++; if (e !== v[i].err) $display("FAIL trap[%0d] err got %b exp %b", i, e, v[i].err); else passed++;
      total++; if (lat != int'(v[i].lat)) $display("FAIL trap[%0d] latency got %0d exp %0d", i, lat, v[i].lat); else passed++;
      total++; if (busy != int'(v[i].lat)) $display("FAIL trap[%0d] ready-low cycles got %0d exp %0d", i, busy, v[i].lat); else passed++;
    end
  endtask

  task automatic test_range_funct3();
    vec_t v [12];
    logic [31:0] r; logic e; int lat, busy, pulses;
    v = '{'{1'b1, 32'h00, 32'h5A5A5A5A, 3'd2, 32'h0,        1'b0, 4'd2},
          '{1'b1, 32'h3C, 32'h01020304, 3'd2, 32'h0,        1'b0, 4'd2},
          '{1'b0, 32'h3C, 32'h0,        3'd2, 32'h01020304, 1'b0, 4'd2},
          '{1'b0, 32'h3D, 32'h0,        3'd2, 32'h0,        1'b1, 4'd1},
          '{1'b1, 32'h40, 32'h00000099, 3'd0, 32'h0,        1'b1, 4'd1},
          '{1'b0, 32'h00, 32'h0,        3'd2, 32'h5A5A5A5A, 1'b0, 4'd2},
          '{1'b0, 32'h00, 32'h0,        3'd3, 32'h0,        1'b1, 4'd1},
          '{1'b0, 32'h00, 32'h0,        3'd6, 32'h0,        1'b1, 4'd1},
          '{1'b1, 32'h00, 32'h0000FFFF, 3'd5, 32'h0,        1'b1, 4'd1},
          '{1'b1, 32'h00, 32'h000000FF, 3'd4, 32'h0,        1'b1, 4'd1},
          '{1'b0, 32'h3E, 32'h0,        3'd5, 32'h00000102, 1'b0, 4'd2},
          '{1'b0, 32'h3F, 32'h0,        3'd1, 32'h0,        1'b1, 4'd1}};
    for (int i = 0; i < 12; i++) begin
      run_req(2, v[i], r, e, lat, busy, pulses);
      total++; if (r !== v[i].rdata) $display("FAIL range[%0d] rdata got %h exp %h", i, r, v[i].rdata); else passed++;
      total++; if (e !== v[i].err) $display("FAIL range[%0d] err got %b exp %b", i, e, v[i].err); else passed++;
      total++; if (lat != int'(v[i].lat)) $display("FAIL range[%0d] latency got %0d exp %0d", i, lat, v[i].lat); else passed++;
    end
  endtask

  task automatic test_reset_mid_split();
    vec_t v [5];
    logic [31:0] r; logic e; int lat, busy, pulses;
    int seen;
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h23; req_wdata = 32'hAABBCCDD; req_funct3 = 3'd2;
    vld = 3'b001;
    @(posedge clk); #1;
    vld = 3'b000;
    seen = rv[0] ? 1 : 0;
    @(posedge clk); #1;
    seen += rv[0] ? 1 : 0;
    rst_n = 1'b0;
    #1;
    total++; if (rdy[0] !== 1'b1) $display("FAIL rst_mid req_ready got %b exp 1", rdy[0]); else passed++;
    repeat (3) begin
      @(posedge clk); #1;
      seen += rv[0] ? 1 : 0;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      seen += rv[0] ? 1 : 0;
    end
    total++; if (seen != 0) $display("FAIL rst_mid resp_valid pulses got %0d exp 0", seen); else passed++;
    total++; if (rdy[0] !== 1'b1) $display("FAIL rst_mid ready_after got %b exp 1", rdy[0]); else passed++;
    v = '{'{1'b0, 32'h23, 32'h0, 3'd4, 32'h000000DD, 1'b0, 4'd2},
          '{1'b0, 32'h24, 32'h0, 3'd4, 32'h00000033, 1'b0, 4'd2},
          '{1'b0, 32'h25, 32'h0, 3'd4, 32'h00000022, 1'b0, 4'd2},
          '{1'b0, 32'h26, 32'h0, 3'd4, 32'h00000011, 1'b0, 4'd2},
          '{1'b0, 32'h10, 32'h0, 3'd2, 32'h135777EF, 1'b0, 4'd2}};
    for (int i = 0; i < 5; i++) begin
      run_req(0, v[i], r, e, lat, busy, pulses);
      total++; if (r !== v[i].rdata) $display("FAIL rst_mid[%0d] rdata got %h exp %h", i, r, v[i].rdata); else passed++;
      total++; if (e !== v[i].err) $display("FAIL rst_mid[%0d] err got %b exp %b", i, e, v[i].err); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_word_access();
    test_subword();
    test_split();
    test_trap();
    test_range_funct3();
    test_reset_mid_split();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_split_ctrl.md
Name: dmem_split_ctrl

Overview:
Parametrised RV32I data memory with a valid/ready request port and a registered response port. It replaces the single-cycle byte-array memory: storage is word-organised with byte lanes, and RV32I load/store widths are decoded per funct3. Accesses that cross a word boundary are split into two beats by an internal FSM, or trapped, depending on a parameter. It sits between the EX/MEM stage and storage, and the pipeline stalls on req_ready/resp_valid.

Parameters:
ADDR_WIDTH, 32, width of the byte address port
DEPTH_WORDS, 1024, number of 32-bit words stored; byte range is 0 to 4*DEPTH_WORDS-1
MISALIGN_SPLIT, 1, 1 = word-crossing accesses are split into two beats; 0 = they complete with resp_err

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
req_funct3  input  3  RV32I funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU (BU/HU are loads only)
resp_valid  output  1  one-cycle pulse, response is valid
resp_rdata  output  32  load result, sign- or zero-extended; 0 for stores and errors
resp_err  output  1  qualified by resp_valid; access was rejected

Behaviour:
- Reset (async, rst_n=0): FSM goes to IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. Memory contents are not reset (zero at time 0 in simulation only).
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE: a request is accepted when req_valid && req_ready. On acceptance, latch addr, we, wdata and funct3, and compute word0 = addr>>2, off = addr[1:0], size = 1/2/4.
- Error checks are made at accept time.
  - Error if req_funct3 is not in {0,1,2,4,5}.
  - Error on a store with funct3 of 4 or 5.
  - Error if the last byte (addr+size-1) is at or beyond 4*DEPTH_WORDS.
  - Error if the access crosses a word (off+size>4) and MISALIGN_SPLIT=0.
  - On error: go directly to RESP with err=1 and make no memory access.
- BEAT0: access word0.
  - Store: write the byte lanes off..min(off+size,4)-1 with data shifted left by 8*off.
  - Load: capture the word.
  - Next state is BEAT1 if the access crosses a word, else RESP.
- BEAT1: access word0+1 on lanes 0..(off+size-5).
  - Store: write the remaining upper data bytes.
  - Load: capture the word.
  - Next state is RESP.
- Load assembly: form the 64-bit value {word1, word0} and shift right by 8*off. Take the low size bytes. funct3 0/1 sign-extend from bit 7/15; 4/5 zero-extend; 2 uses all 32 bits.
- RESP: resp_valid=1 for exactly one cycle with rdata/err, then return to IDLE. req_ready=0 outside IDLE, so there is no back-to-back accept in the RESP cycle.
- Latency (accept edge to the cycle resp_valid is high): aligned or non-crossing access, 2 cycles; crossing access, 3 cycles; error, 1 cycle.
- Unaligned but non-crossing accesses (e.g. LH at off=1) are single-beat and legal.
- Address wrap: word0+1 is never beyond range, because the range check already covers the last byte.
- Reset mid-operation: the FSM aborts to IDLE and no response is issued. A BEAT0 store already committed stays in memory; the BEAT1 half is never written.
- Inputs are ignored when req_ready=0.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_rdata 0xDEADBEEF, err=0, resp_valid 2 cycles after each accept.
- Using the word above, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- MISALIGN_SPLIT=1: SW addr 0x23 data 0x11223344 -> byte 0x23=0x44 and bytes 0x24..0x26=0x33,0x22,0x11. LW 0x23 -> 0x11223344 with 3-cycle latency, req_ready low for 3 cycles.
- MISALIGN_SPLIT=0: LH 0x07 -> resp_err=1, rdata=0, 1-cycle latency, memory unchanged. LH 0x05 -> no error.
- DEPTH_WORDS=16: LW 0x3C -> ok; LW 0x3D -> err; SB 0x40 -> err with no write. funct3=3, 6 and SHU -> err.
- Split SW 0x23 of 0xAABBCCDD with rst_n pulsed low during BEAT1 -> resp_valid never asserts, byte 0x23=0xDD, bytes 0x24..0x26 unchanged, req_ready=1 after reset.
